// File: rtl/su_rr_arbiter_if.sv
// -----------------------------------------------------------------------------
// su_rr_arbiter_if
// Bundles the requester-side and su-side signals of the round-robin subtract
// unit arbiter.
//   req_valid/req_a/req_b  : per-requester request and packed operands
//   req_ready              : one-hot accept back to the requesters
//   rsp_valid/rsp_c/rsp_err: one-hot result pulse, result value, timeout flag
//   busy                   : arbiter is not idle
//   su_start/su_a/su_b     : command to the shared subtract unit
//   su_done/su_c           : completion and result from the subtract unit
// Modports: slave  = arbiter view, master = environment (requesters + su) view.
// -----------------------------------------------------------------------------
`ifndef BIT_WIDTH
`define BIT_WIDTH 16
`endif

interface su_rr_arbiter_if #(
   parameter int NREQ = 4,
   parameter int W    = `BIT_WIDTH
);
   logic [NREQ-1:0]   req_valid;
   logic [NREQ*W-1:0] req_a;
   logic [NREQ*W-1:0] req_b;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ-1:0]   rsp_valid;
   logic [W-1:0]      rsp_c;
   logic              rsp_err;
   logic              busy;
   logic              su_start;
   logic [W-1:0]      su_a;
   logic [W-1:0]      su_b;
   logic              su_done;
   logic [W-1:0]      su_c;

   modport slave (
      input  req_valid, req_a, req_b, su_done, su_c,
      output req_ready, rsp_valid, rsp_c, rsp_err, busy, su_start, su_a, su_b
   );

   modport master (
      output req_valid, req_a, req_b, su_done, su_c,
      input  req_ready, rsp_valid, rsp_c, rsp_err, busy, su_start, su_a, su_b
   );
endinterface

// File: rtl/su_rr_arbiter.sv
// -----------------------------------------------------------------------------
// su_rr_arbiter
// Shares one start/done subtract unit (c = a - b) between NREQ requesters.
// A round-robin pick accepts one request, latches its operands, pulses
// su_start, waits for su_done (bounded by TIMEOUT cycles) and returns the
// result to the originating requester with a one-cycle rsp_valid pulse.
// Ports:
//   clk  : clock
//   rst  : synchronous reset, active-high
//   bus  : su_rr_arbiter_if.slave (requester handshake, response, su command)
// -----------------------------------------------------------------------------
`ifndef BIT_WIDTH
`define BIT_WIDTH 16
`endif

module su_rr_arbiter #(
   parameter int NREQ    = 4,
   parameter int W       = `BIT_WIDTH,
   parameter int TIMEOUT = 16
) (
   input  logic           clk,
   input  logic           rst,
   su_rr_arbiter_if.slave bus
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t        state_q, state_d;
   logic [IW-1:0] ptr_q, ptr_d;
   logic [IW-1:0] gid_q, gid_d;
   logic [W-1:0]  op_a_q, op_a_d;
   logic [W-1:0]  op_b_q, op_b_d;
   logic [W-1:0]  res_q, res_d;
   logic          err_q, err_d;
   logic [CW-1:0] tmo_q, tmo_d;

   logic          found;
   logic [IW-1:0] pick;
   int            idx;

   // Round-robin search starting at ptr_q; first pending requester wins.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      idx   = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(ptr_q) + k) % NREQ;
         if (!found && bus.req_valid[idx]) begin
            found = 1'b1;
            pick  = IW'(idx);
         end
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gid_d   = gid_q;
      op_a_d  = op_a_q;
      op_b_d  = op_b_q;
      res_d   = res_q;
      err_d   = err_q;
      tmo_d   = tmo_q;
      unique case (state_q)
         S_IDLE: begin
            if (found) begin
               gid_d   = pick;
               op_a_d  = bus.req_a[int'(pick)*W +: W];
               op_b_d  = bus.req_b[int'(pick)*W +: W];
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            tmo_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (bus.su_done) begin
               res_d   = bus.su_c;
               err_d   = 1'b0;
               state_d = S_RESP;
            end else if (tmo_q == CW'(TIMEOUT - 1)) begin
               // Give up: the requester still gets a response, flagged as error.
               res_d   = '0;
               err_d   = 1'b1;
               state_d = S_RESP;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         S_RESP: begin
            // Priority moves past the requester just served.
            if (int'(gid_q) == NREQ - 1) begin
               ptr_d = '0;
            end else begin
               ptr_d = gid_q + 1'b1;
            end
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         gid_q   <= '0;
         op_a_q  <= '0;
         op_b_q  <= '0;
         res_q   <= '0;
         err_q   <= 1'b0;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gid_q   <= gid_d;
         op_a_q  <= op_a_d;
         op_b_q  <= op_b_d;
         res_q   <= res_d;
         err_q   <= err_d;
         tmo_q   <= tmo_d;
      end
   end

   // Outputs. su operands come straight from the latched copies so they stay
   // stable for the whole operation even if the requester changes its inputs.
   always_comb begin
      bus.req_ready = '0;
      bus.rsp_valid = '0;
      bus.rsp_c     = '0;
      bus.rsp_err   = 1'b0;
      if (state_q == S_IDLE && found) begin
         bus.req_ready[pick] = 1'b1;
      end
      if (state_q == S_RESP) begin
         bus.rsp_valid[gid_q] = 1'b1;
         bus.rsp_c            = res_q;
         bus.rsp_err          = err_q;
      end
   end

   assign bus.busy     = (state_q != S_IDLE);
   assign bus.su_start = (state_q == S_ISSUE);
   assign bus.su_a     = op_a_q;
   assign bus.su_b     = op_b_q;

endmodule

// File: tb/tb_su_rr_arbiter.sv
`ifndef BIT_WIDTH
`define BIT_WIDTH 16
`endif

module tb_su_rr_arbiter;
   localparam int NREQ    = 4;
   localparam int W       = `BIT_WIDTH;
   localparam int TIMEOUT = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   su_rr_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

   su_rr_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      int           idx;
      logic [W-1:0] c;
      logic         err;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks   = 0;
   int   failures = 0;
   int   rsp_cnt  = 0;
   int   rsp_cyc  = 0;
   int   cyc      = 0;

   // Subtract unit stand-in: done two cycles after start, c combinational.
   logic [1:0] su_pipe;
   logic       su_en;
   logic       force_done;
   always @(posedge clk) begin
      if (rst) su_pipe <= 2'b00;
      else     su_pipe <= {su_pipe[0], bus.su_start};
   end
   assign bus.su_done = (su_pipe[1] & su_en) | force_done;
   assign bus.su_c    = bus.su_a - bus.su_b;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Response monitor: every rsp pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (!rst && bus.rsp_valid !== '0) begin
         rsp_cnt++;
         rsp_cyc = cyc;
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_rsp actual=%0b required=none", bus.rsp_valid);
         end else begin
            mon_e = exp_q.pop_front();
            check("rsp_valid", 64'(bus.rsp_valid), 64'(1) << mon_e.idx);
            check("rsp_c", 64'(bus.rsp_c), 64'(mon_e.c));
            check("rsp_err", 64'(bus.rsp_err), 64'(mon_e.err));
         end
      end
   end

   task automatic push_exp(input int i, input logic [W-1:0] c, input logic e);
      exp_t ex;
      ex.idx = i;
      ex.c   = c;
      ex.err = e;
      exp_q.push_back(ex);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.req_valid = '0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic wait_ready(input int i, input string tag, output bit ok);
      int n;
      n = 0;
      #1;
      while (bus.req_ready[i] !== 1'b1 && n < 64) begin
         @(posedge clk);
         #1;
         n++;
      end
      ok = (bus.req_ready[i] === 1'b1);
      if (!ok) begin
         checks++;
         failures++;
         $display("FAIL %s_accept actual=no_ready required=ready", tag);
      end
   endtask

   task automatic run_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] c, input logic e, input string tag);
      int n;
      int acc;
      int start;
      bit ok;
      bus.req_a[i*W +: W] = a;
      bus.req_b[i*W +: W] = b;
      bus.req_valid[i]    = 1'b1;
      wait_ready(i, tag, ok);
      if (!ok) begin
         bus.req_valid[i] = 1'b0;
         return;
      end
      push_exp(i, c, e);
      acc   = cyc;
      start = rsp_cnt;
      @(posedge clk);
      #1;
      bus.req_valid[i] = 1'b0;
      n = 0;
      while (rsp_cnt == start && n < TIMEOUT + 16) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (rsp_cnt == start) begin
         checks++;
         failures++;
         $display("FAIL %s_rsp actual=none required=response", tag);
      end else begin
         check({tag, "_latency"}, 64'(rsp_cyc - acc), e ? 64'(TIMEOUT + 2) : 64'(4));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int start;
      bit ok;
      rst           = 1'b1;
      su_en         = 1'b1;
      force_done    = 1'b0;
      bus.req_valid = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      do_reset();

      // Reset state
      check("rst_req_ready", 64'(bus.req_ready), 64'(0));
      check("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
      check("rst_busy", 64'(bus.busy), 64'(0));
      check("rst_su_start", 64'(bus.su_start), 64'(0));
      check("rst_su_ab", {32'(bus.su_a), 32'(bus.su_b)}, 64'(0));
      check("rst_rsp_c_err", {32'(bus.rsp_c), 32'(bus.rsp_err)}, 64'(0));

      // 1: single op 10-3 with cycle-exact timing
      bus.req_a[0 +: W] = W'(10);
      bus.req_b[0 +: W] = W'(3);
      bus.req_valid     = 4'b0001;
      #1;
      check("t1_ready", 64'(bus.req_ready), 64'b0001);
      push_exp(0, W'(7), 1'b0);
      @(posedge clk); #1;
      check("t1_ready_one_cycle", 64'(bus.req_ready), 64'(0));
      bus.req_valid = '0;
      check("t1_su_start", 64'(bus.su_start), 64'(1));
      check("t1_su_a", 64'(bus.su_a), 64'(10));
      check("t1_su_b", 64'(bus.su_b), 64'(3));
      check("t1_busy", 64'(bus.busy), 64'(1));
      @(posedge clk); #1;
      check("t1_su_start_pulse", 64'(bus.su_start), 64'(0));
      @(posedge clk); #1;
      check("t1_no_early_rsp", 64'(bus.rsp_valid), 64'(0));
      @(posedge clk); #1;
      check("t1_rsp_at_t4", 64'(bus.rsp_valid), 64'b0001);
      check("t1_rsp_c", 64'(bus.rsp_c), 64'(7));
      @(posedge clk); #1;
      check("t1_idle_after", 64'(bus.busy), 64'(0));

      // 2: borrow wraps to all-ones
      run_op(1, W'(0), W'(1), {W{1'b1}}, 1'b0, "t2_wrap");

      // 3: fairness with all four requesters pending
      do_reset();
      for (int i = 0; i < NREQ; i++) begin
         bus.req_a[i*W +: W] = W'(i + 5);
         bus.req_b[i*W +: W] = W'(i);
      end
      push_exp(0, W'(5), 1'b0);
      push_exp(1, W'(5), 1'b0);
      push_exp(2, W'(5), 1'b0);
      push_exp(3, W'(5), 1'b0);
      push_exp(0, W'(5), 1'b0);
      start = rsp_cnt;
      bus.req_valid = 4'b1111;
      n = 0;
      while (rsp_cnt < start + 5 && n < 80) begin
         @(posedge clk); #1;
         n++;
      end
      bus.req_valid = '0;
      check("t3_rsp_count", 64'(rsp_cnt - start), 64'(5));
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("t3_idle", 64'(bus.busy), 64'(0));
      check("t3_queue_drained", 64'(exp_q.size()), 64'(0));

      // 4: timeout, then a late done in IDLE must do nothing
      su_en = 1'b0;
      run_op(2, W'(9), W'(4), W'(0), 1'b1, "t4_timeout");
      force_done = 1'b1;
      @(posedge clk); #1;
      force_done = 1'b0;
      check("t4_late_done_busy", 64'(bus.busy), 64'(0));
      check("t4_late_done_rsp", 64'(bus.rsp_valid), 64'(0));
      @(posedge clk); #1;
      check("t4_late_done_start", 64'(bus.su_start), 64'(0));
      su_en = 1'b1;
      run_op(1, W'(7), W'(9), W'(16'hFFFE), 1'b0, "t4_after");

      // 5: reset in WAIT aborts silently, ptr returns to 0
      su_en = 1'b0;
      bus.req_a[2*W +: W] = W'(20);
      bus.req_b[2*W +: W] = W'(5);
      bus.req_valid[2]    = 1'b1;
      wait_ready(2, "t5", ok);
      @(posedge clk); #1;
      bus.req_valid = '0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      bus.req_valid[0] = 1'b1;
      #1;
      check("t5_busy_no_ready", 64'(bus.req_ready), 64'(0));
      check("t5_busy", 64'(bus.busy), 64'(1));
      bus.req_valid = '0;
      rst = 1'b1;
      @(posedge clk); #1;
      check("t5_rst_busy", 64'(bus.busy), 64'(0));
      check("t5_rst_su", {31'(bus.su_a), 32'(bus.su_b), bus.su_start}, 64'(0));
      check("t5_rst_rsp", {31'(bus.rsp_c), 32'(bus.rsp_valid), bus.rsp_err}, 64'(0));
      rst   = 1'b0;
      su_en = 1'b1;
      bus.req_valid = 4'b1111;
      #1;
      check("t5_ptr_zero", 64'(bus.req_ready), 64'b0001);
      bus.req_valid = '0;
      run_op(0, W'(100), W'(58), W'(42), 1'b0, "t5_after");

      // 6: operands latched at accept
      bus.req_a[1*W +: W] = W'(50);
      bus.req_b[1*W +: W] = W'(8);
      bus.req_valid[1]    = 1'b1;
      wait_ready(1, "t6", ok);
      if (ok) push_exp(1, W'(42), 1'b0);
      @(posedge clk); #1;
      bus.req_valid       = '0;
      bus.req_a[1*W +: W] = W'(999);
      bus.req_b[1*W +: W] = W'(1);
      for (int k = 0; k < 4; k++) begin
         check("t6_su_a_stable", 64'(bus.su_a), 64'(50));
         check("t6_su_b_stable", 64'(bus.su_b), 64'(8));
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      check("t6_queue_drained", 64'(exp_q.size()), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
